// File: rtl/pshift_pkg.sv
// pshift_pkg: shared state encoding and width helper for the serial transmitter.
package pshift_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/pshift_cnt.sv
// pshift_cnt: up-counter with synchronous clear and a terminal-count flag.
module pshift_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == max;
endmodule

// File: rtl/pshift_tx.sv
// pshift_tx: parallel-to-serial transmitter with first/last strobes and idle gaps.
module pshift_tx
  import pshift_pkg::*;
#(
  parameter int DW        = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          sout,
  output logic          sout_valid,
  output logic          sout_first,
  output logic          sout_last,
  output logic          busy
);
  localparam int BW = clog2(DW);
  state_t state_q, state_d;
  logic [DW-1:0] sh_q, sh_d;
  logic sout_q, sout_d, sv_q, sv_d, sf_q, sf_d, sl_q, sl_d;
  logic bit_clr, bit_inc, bit_tc, gap_clr, gap_inc, gap_tc, accept, cur_bit;
  pshift_cnt #(.W(BW)) u_bit (
    .clk(clk), .rstn(rstn), .clr(bit_clr), .inc(bit_inc), .max(BW'(DW - 1)), .tc(bit_tc)
  );
  pshift_cnt #(.W(4)) u_gap (
    .clk(clk), .rstn(rstn), .clr(gap_clr), .inc(gap_inc), .max(4'(GAP > 0 ? GAP - 1 : 0)), .tc(gap_tc)
  );
  assign din_ready = rstn && (state_q == S_IDLE || (state_q == S_SHIFT && bit_tc && GAP == 0));
  assign accept = din_valid && din_ready;
  assign cur_bit = MSB_FIRST ? sh_q[DW-1] : sh_q[0];
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    sout_d = 1'b0;
    sv_d = 1'b0;
    sf_d = 1'b0;
    sl_d = 1'b0;
    bit_clr = 1'b0;
    bit_inc = 1'b0;
    gap_clr = 1'b0;
    gap_inc = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_SHIFT;
        sh_d = din;
        bit_clr = 1'b1;
      end
      S_SHIFT: begin
        // a word starts right after an idle output or right after a last bit
        sout_d = cur_bit;
        sv_d = 1'b1;
        sf_d = !sv_q || sl_q;
        sl_d = bit_tc;
        sh_d = MSB_FIRST ? {sh_q[DW-2:0], 1'b0} : {1'b0, sh_q[DW-1:1]};
        bit_inc = !bit_tc;
        bit_clr = bit_tc;
        if (bit_tc) begin
          if (GAP > 0) state_d = S_GAP;
          else if (accept) sh_d = din;
          else state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gap_inc = !gap_tc;
        gap_clr = gap_tc;
        if (gap_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      sout_q <= 1'b0;
      sv_q <= 1'b0;
      sf_q <= 1'b0;
      sl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      sout_q <= sout_d;
      sv_q <= sv_d;
      sf_q <= sf_d;
      sl_q <= sl_d;
    end
  assign sout = sout_q;
  assign sout_valid = sv_q;
  assign sout_first = sf_q;
  assign sout_last = sl_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_pshift_tx.sv
// tb_pshift_tx: four transmitter configurations checked against a timing/bit-order model.
module tb_pshift_tx;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam bit MSBF [NC] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int GAPS [NC] = '{1, 1, 0, 3};
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [DW-1:0] din [NC];
  logic dv [NC], rdy [NC], so [NC], sv [NC], sf [NC], sl [NC], bsy [NC];
  int vectors = 0, miscompares = 0, cyc = 0;
  int acc [NC], pacc [NC], sent [NC];
  logic [DW-1:0] wrd [NC], pwrd [NC];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : g_dut
    pshift_tx #(.DW(DW), .MSB_FIRST(MSBF[g]), .GAP(GAPS[g])) u_dut (
      .clk(clk), .rstn(rstn), .din(din[g]), .din_valid(dv[g]), .din_ready(rdy[g]),
      .sout(so[g]), .sout_valid(sv[g]), .sout_first(sf[g]), .sout_last(sl[g]), .busy(bsy[g])
    );
  end
  // expected {sout, valid, first, last} after edge m, from the most recent accept before m
  function automatic logic [3:0] m_out(input int ch, input int m);
    int a, i;
    logic [DW-1:0] w;
    a = (m > acc[ch]) ? acc[ch] : pacc[ch];
    w = (m > acc[ch]) ? wrd[ch] : pwrd[ch];
    i = m - a - 1;
    if (i < 0 || i >= DW) return 4'b0000;
    return {(MSBF[ch] ? w[DW-1-i] : w[i]), 1'b1, i == 0, i == DW - 1};
  endfunction
  function automatic logic m_busy(input int ch, input int c);
    return c >= acc[ch] && c <= acc[ch] + DW + GAPS[ch] - 1;
  endfunction
  function automatic logic m_ready(input int ch, input int c);
    return rstn && !(c >= acc[ch] && c < acc[ch] + (GAPS[ch] == 0 ? DW - 1 : DW + GAPS[ch]));
  endfunction
  task automatic chk(input string tag, input int ch, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s ch%0d cyc %0d: observed %b expected %b", tag, ch, cyc, obs, exp);
    end
  endtask
  task automatic check_outs();
    for (int ch = 0; ch < NC; ch++) begin
      logic [3:0] e;
      e = m_out(ch, cyc);
      chk("sout", ch, so[ch], e[3]);
      chk("sout_valid", ch, sv[ch], e[2]);
      chk("sout_first", ch, sf[ch], e[1]);
      chk("sout_last", ch, sl[ch], e[0]);
      chk("busy", ch, bsy[ch], m_busy(ch, cyc));
    end
  endtask
  task automatic mreset();
    for (int ch = 0; ch < NC; ch++) begin
      acc[ch] = -1000;
      pacc[ch] = -1000;
    end
  endtask
  task automatic step();
    #1;
    for (int ch = 0; ch < NC; ch++) begin
      chk("din_ready", ch, rdy[ch], m_ready(ch, cyc));
      if (dv[ch] && m_ready(ch, cyc)) begin
        pacc[ch] = acc[ch];
        pwrd[ch] = wrd[ch];
        acc[ch] = cyc + 1;
        wrd[ch] = din[ch];
        sent[ch]++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outs();
  endtask
  initial begin
    for (int ch = 0; ch < NC; ch++) begin
      dv[ch] = 1'b0;
      din[ch] = '0;
      sent[ch] = 0;
      wrd[ch] = '0;
      pwrd[ch] = '0;
    end
    mreset();
    step();
    step();
    rstn = 1'b1;
    repeat (30) begin
      dv[0] = sent[0] == 0;
      din[0] = 8'hA5;
      dv[1] = sent[1] == 0;
      din[1] = 8'h01;
      dv[2] = sent[2] < 2;
      din[2] = sent[2] == 0 ? 8'hFF : 8'h00;
      dv[3] = 1'b1;
      din[3] = 8'($urandom);
      step();
    end
    for (int ch = 1; ch < NC; ch++) dv[ch] = 1'b0;
    dv[0] = 1'b1;
    din[0] = 8'hC3;
    step();
    dv[0] = 1'b0;
    repeat (4) step();
    rstn = 1'b0;
    mreset();
    #1;
    check_outs();
    for (int ch = 0; ch < NC; ch++) chk("din_ready_rst", ch, rdy[ch], 1'b0);
    dv[0] = 1'b1;
    din[0] = 8'h3C;
    step();
    step();
    rstn = 1'b1;
    begin
      int s0;
      s0 = sent[0];
      repeat (14) begin
        dv[0] = sent[0] == s0;
        step();
      end
    end
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < NC; ch++) begin
        dv[ch] = $urandom_range(3) != 0;
        din[ch] = 8'($urandom);
      end
      if (i == 250) begin
        rstn = 1'b0;
        mreset();
        #1;
        check_outs();
        step();
        rstn = 1'b1;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pshift_tx.md
Name: pshift_tx

Overview:
- Parallel-to-serial transmitter. It is the sending end of the team's register-chain data path.
- Accepts a DW-bit word through a valid/ready handshake.
- Shifts the word out one bit per clock, with valid, first and last strobes, to a serial capture chain downstream.
- Inserts a programmable number of idle gap cycles between words.

Parameters:
- DW, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit DW-1 is sent first; 0 = bit 0 is sent first.
- GAP, 1, idle cycles between the last bit of one word and the first bit of the next; legal range 0..15.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rstn  input  1  reset, asynchronous, active-low.
- din  input  DW  parallel word to send.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block accepts din this cycle.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout holds a bit of a word, registered.
- sout_first  output  1  first bit of a word, registered.
- sout_last  output  1  last bit of a word, registered.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset, with rstn low asynchronously:
  - state = IDLE; shift register = 0; bit counter = 0; gap counter = 0.
  - sout, sout_valid, sout_first and sout_last = 0; busy = 0.
  - din_ready = 0 while rstn is low.
- Handshake:
  - A word is accepted at a rising edge where din_valid && din_ready.
  - din is sampled at that edge only; later changes on din are ignored.
  - din_valid may drop without completing a transfer.
- din_ready is combinational from state and counters, never from din_valid. It is high when either:
  - state == IDLE, or
  - state == SHIFT && bit counter == DW-1 && GAP == 0 (back-to-back case).
- FSM states:
  - IDLE: on accept, load the shift register with din, clear the bit counter, go to SHIFT.
  - SHIFT:
    - Each cycle, drive the current bit, shift by one toward the output end, and increment the bit counter.
    - When the bit counter reaches DW-1, this is the last bit.
    - Next state: GAP if GAP > 0. If GAP == 0, go to SHIFT when a new word is accepted in the same cycle, otherwise IDLE.
  - GAP:
    - Count GAP cycles with sout_valid = 0, then go to IDLE.
    - din_ready stays 0 for the whole GAP state.
- Latency and timing:
  - If the accept happens at edge N, the first bit appears on sout with sout_valid = 1 after edge N+1.
  - sout_first = 1 with that first bit only.
  - Bits continue for DW consecutive cycles; sout_last = 1 on the DW-th bit.
- Words:
  - With GAP = 0 and continuous din_valid, sout_valid stays high indefinitely and the words are contiguous.
  - The minimum word period is DW + GAP + 1 cycles when GAP > 0, and DW cycles when GAP = 0.
- Idle outputs: when sout_valid = 0, sout, sout_first and sout_last are 0.
- Bit order:
  - MSB_FIRST = 1: bit sequence din[DW-1] … din[0].
  - MSB_FIRST = 0: bit sequence din[0] … din[DW-1].
- Widths:
  - Bit counter is $clog2(DW) bits.
  - Gap counter is 4 bits.
  - No arithmetic beyond counter increments. The counters never wrap during normal operation because they are compared against their terminal value.
- Boundary conditions:
  - din_valid while busy and not ready: no accept; the word is held off by the upstream source.
  - Reset mid-word: outputs clear immediately; the partial word is discarded and never resumed.
  - Reset released: first accept is possible on the first rising edge after rstn goes high.

Decomposition:
- Shared package pshift_pkg holds:
  - state encoding typedef: IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2.
  - function for counter width, clog2.
- One sub-module, pshift_cnt: a generic up-counter with terminal-count flag. It is instantiated twice, as the bit counter and the gap counter.
- The FSM and shift register stay in the top level.

Test Plan:
- DW=8, MSB_FIRST=1, GAP=1; send din=8'hA5 once:
  - sout sequence = 1,0,1,0,0,1,0,1 over 8 cycles, starting one cycle after accept.
  - sout_first on cycle 1, sout_last on cycle 8.
  - busy high for 9 cycles; din_ready high again on the 10th.
- MSB_FIRST=0, din=8'h01: sout = 1 then seven 0s.
- GAP=0, din_valid held with 8'hFF then 8'h00:
  - 16 contiguous valid bits, eight 1s then eight 0s.
  - din_ready pulses on the last bit of the first word; no idle cycle between words.
- GAP=3; din_valid held while busy:
  - din_ready stays low for 8 shift + 3 gap cycles.
  - The second word starts exactly 12 cycles after the first accept, plus 1 cycle of latency.
- Assert rstn low after 4 bits of 8'hC3:
  - all outputs are 0 immediately.
  - after release, sending 8'h3C produces only 0,0,1,1,1,1,0,0, with no residue of the old word.
- din_valid pulses low for one cycle before an accept, with din changing while not ready: the transmitted word equals din at the accept edge only.
